// File: rtl/axil_wr_demux_n.sv
// AXI-Lite write demux: one upstream master to NUM_SLV slaves, one outstanding write,
// route latched at AW, DECERR for undecodable routes. Optional: AXIL_WR_DEMUX_BRESP_REG_EN.
module axil_wr_demux_n #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_SLV        = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_SLV)
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [SEL_WIDTH-1:0]                  slv_sel,
  input  logic                                  slv_invalid,
  input  logic [AXI_ADDR_WIDTH-1:0]             m_axil_awaddr,
  input  logic                                  m_axil_awvalid,
  output logic                                  m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]             m_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]           m_axil_wstrb,
  input  logic                                  m_axil_wvalid,
  output logic                                  m_axil_wready,
  output logic [1:0]                            m_axil_bresp,
  output logic                                  m_axil_bvalid,
  input  logic                                  m_axil_bready,
  output logic [NUM_SLV*AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  output logic [NUM_SLV-1:0]                    s_axil_awvalid,
  input  logic [NUM_SLV-1:0]                    s_axil_awready,
  output logic [NUM_SLV*AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  output logic [NUM_SLV*AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic [NUM_SLV-1:0]                    s_axil_wvalid,
  input  logic [NUM_SLV-1:0]                    s_axil_wready,
  input  logic [NUM_SLV*2-1:0]                  s_axil_bresp,
  input  logic [NUM_SLV-1:0]                    s_axil_bvalid,
  output logic [NUM_SLV-1:0]                    s_axil_bready
);

  localparam logic [SEL_WIDTH:0] NUM_SLV_W = (SEL_WIDTH+1)'(NUM_SLV);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FWD      = 3'd1,
    RESP     = 3'd2,
    ERR_DATA = 3'd3,
    ERR_RESP = 3'd4
  } state_e;

  state_e               state_r;
  logic [SEL_WIDTH-1:0] sel_r;
  logic                 aw_done_r;
  logic                 w_done_r;

  logic [NUM_SLV-1:0]   sel_oh_s;
  logic                 sel_awready_s;
  logic                 sel_wready_s;
  logic                 sel_bvalid_s;
  logic [1:0]           sel_bresp_s;
  logic                 route_bad_s;
  logic                 aw_done_s;
  logic                 w_done_s;
  logic                 b_hs_s;

`ifdef AXIL_WR_DEMUX_BRESP_REG_EN
  logic                 bfull_r;
  logic [1:0]           bresp_r;
`endif

  assign route_bad_s = slv_invalid | ({1'b0, slv_sel} >= NUM_SLV_W);
  assign aw_done_s   = aw_done_r | (m_axil_awvalid & m_axil_awready);
  assign w_done_s    = w_done_r  | (m_axil_wvalid  & m_axil_wready);
  assign b_hs_s      = m_axil_bvalid & m_axil_bready;

  // Decode the latched route into a one-hot mask and pick the selected slave's return signals
  always_comb begin
    sel_oh_s      = '0;
    sel_awready_s = 1'b0;
    sel_wready_s  = 1'b0;
    sel_bvalid_s  = 1'b0;
    sel_bresp_s   = 2'b00;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_oh_s[i]   = (sel_r == SEL_WIDTH'(i));
      sel_awready_s = sel_awready_s | (sel_oh_s[i] & s_axil_awready[i]);
      sel_wready_s  = sel_wready_s  | (sel_oh_s[i] & s_axil_wready[i]);
      sel_bvalid_s  = sel_bvalid_s  | (sel_oh_s[i] & s_axil_bvalid[i]);
      sel_bresp_s   = sel_bresp_s   | (sel_oh_s[i] ? s_axil_bresp[2*i +: 2] : 2'b00);
    end
  end

  // Channel steering per state; payloads are broadcast only while forwarding so idle outputs stay 0
  always_comb begin
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bvalid  = 1'b0;
    m_axil_bresp   = 2'b00;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_bready  = '0;
    s_axil_awaddr  = '0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    case (state_r)
      FWD: begin
        m_axil_awready = sel_awready_s & ~aw_done_r;
        m_axil_wready  = sel_wready_s & ~w_done_r;
        s_axil_awvalid = sel_oh_s & {NUM_SLV{m_axil_awvalid & ~aw_done_r}};
        s_axil_wvalid  = sel_oh_s & {NUM_SLV{m_axil_wvalid & ~w_done_r}};
        s_axil_awaddr  = {NUM_SLV{m_axil_awaddr}};
        s_axil_wdata   = {NUM_SLV{m_axil_wdata}};
        s_axil_wstrb   = {NUM_SLV{m_axil_wstrb}};
      end
      RESP: begin
`ifdef AXIL_WR_DEMUX_BRESP_REG_EN
        s_axil_bready = sel_oh_s & {NUM_SLV{~bfull_r}};
        m_axil_bvalid = bfull_r;
        m_axil_bresp  = bfull_r ? bresp_r : 2'b00;
`else
        s_axil_bready = sel_oh_s & {NUM_SLV{m_axil_bready}};
        m_axil_bvalid = sel_bvalid_s;
        m_axil_bresp  = sel_bvalid_s ? sel_bresp_s : 2'b00;
`endif
      end
      ERR_DATA: begin
        m_axil_awready = ~aw_done_r;
        m_axil_wready  = ~w_done_r;
      end
      ERR_RESP: begin
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = 2'b11;
      end
      default: begin
        m_axil_bvalid = 1'b0;
      end
    endcase
  end

  // Transaction FSM: latch route in IDLE, track AW/W completion, release on the B handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= IDLE;
      sel_r     <= '0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m_axil_awvalid) begin
            sel_r   <= slv_sel;
            state_r <= route_bad_s ? ERR_DATA : FWD;
          end
        end
        FWD, ERR_DATA: begin
          aw_done_r <= aw_done_s;
          w_done_r  <= w_done_s;
          if (aw_done_s && w_done_s) begin
            state_r <= (state_r == FWD) ? RESP : ERR_RESP;
          end
        end
        RESP, ERR_RESP: begin
          if (b_hs_s) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIL_WR_DEMUX_BRESP_REG_EN
  // One-entry B skid register: filled from the selected slave, drained by the upstream handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bfull_r <= 1'b0;
      bresp_r <= 2'b00;
    end else if (state_r == RESP && !bfull_r && sel_bvalid_s) begin
      bfull_r <= 1'b1;
      bresp_r <= sel_bresp_s;
    end else if (b_hs_s) begin
      bfull_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_axil_wr_demux_n.sv
// Scoreboard bench for axil_wr_demux_n: randomized writes, randomized slave models,
// expected routes/responses queued at issue time and checked by independent monitors.
module tb_axil_wr_demux_n;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 3;

  typedef struct {
    int            slv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW/8-1:0] strb;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [SW-1:0] slv_sel = '0;
  logic slv_invalid = 1'b0;
  logic [AW-1:0] m_awaddr = '1;
  logic m_awvalid = 1'b0, m_awready;
  logic [DW-1:0] m_wdata = '1;
  logic [DW/8-1:0] m_wstrb = '1;
  logic m_wvalid = 1'b0, m_wready;
  logic [1:0] m_bresp;
  logic m_bvalid, m_bready = 1'b0;
  logic [NS*AW-1:0] s_awaddr;
  logic [NS-1:0] s_awvalid, s_awready = '0;
  logic [NS*DW-1:0] s_wdata;
  logic [NS*DW/8-1:0] s_wstrb;
  logic [NS-1:0] s_wvalid, s_wready = '0;
  logic [2*NS-1:0] s_bresp = '0;
  logic [NS-1:0] s_bvalid = '0, s_bready;

  int checks = 0;
  int errors = 0;
  int cur_dest = -1;
  bit aw_open = 1'b0;
  bit hold_b = 1'b0;

  exp_t exp_slv_q[$];
  logic [1:0] exp_b_q[$];
  logic [1:0] rsp_q[$];

  bit got_aw[NS], got_w[NS], b_pend[NS], b_fire[NS], s_b_hs[NS];
  int b_dly[NS];
  logic [AW-1:0] cap_addr[NS];
  logic [DW-1:0] cap_data[NS];
  logic [DW/8-1:0] cap_strb[NS];
  exp_t e_mon;
  logic [1:0] b_exp;

  axil_wr_demux_n #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_SLV(NS), .SEL_WIDTH(SW)) dut (
    .aclk(aclk), .aresetn(aresetn), .slv_sel(slv_sel), .slv_invalid(slv_invalid),
    .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .s_axil_awaddr(s_awaddr), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
    .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
    .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready)
  );

  always #5 aclk = ~aclk;

  // Slave-side monitor: capture slave handshakes and compare each completed write with the queued route
  always @(negedge aclk) begin
    for (int i = 0; i < NS; i++) begin
      b_fire[i] = 1'b0;
      if (!aresetn) begin
        got_aw[i] = 1'b0; got_w[i] = 1'b0; b_pend[i] = 1'b0; s_b_hs[i] = 1'b0;
      end else begin
        s_b_hs[i] = s_bvalid[i] && s_bready[i];
        if (b_pend[i] && !hold_b) begin
          if (b_dly[i] == 0) begin b_fire[i] = 1'b1; b_pend[i] = 1'b0; end
          else b_dly[i] = b_dly[i] - 1;
        end
        if (s_awvalid[i] && s_awready[i]) begin got_aw[i] = 1'b1; cap_addr[i] = s_awaddr[i*AW +: AW]; end
        if (s_wvalid[i] && s_wready[i]) begin
          got_w[i] = 1'b1; cap_data[i] = s_wdata[i*DW +: DW]; cap_strb[i] = s_wstrb[i*DW/8 +: DW/8];
        end
        if (got_aw[i] && got_w[i]) begin
          got_aw[i] = 1'b0; got_w[i] = 1'b0; b_pend[i] = 1'b1; b_dly[i] = $urandom_range(0, 3);
          checks++;
          if (exp_slv_q.size() == 0) begin
            errors++;
            $display("FAIL slave_write: slave %0d got unexpected write addr=%h, expected none", i, cap_addr[i]);
          end else begin
            e_mon = exp_slv_q.pop_front();
            if (e_mon.slv != i || e_mon.addr != cap_addr[i] || e_mon.data != cap_data[i] || e_mon.strb != cap_strb[i]) begin
              errors++;
              $display("FAIL slave_write: got slave=%0d addr=%h data=%h strb=%h, expected slave=%0d addr=%h data=%h strb=%h",
                       i, cap_addr[i], cap_data[i], cap_strb[i], e_mon.slv, e_mon.addr, e_mon.data, e_mon.strb);
            end
          end
        end
      end
    end
  end

  // Slave models: random ready stalls and B responses taken from the response queue
  always @(posedge aclk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (!aresetn) begin
        s_awready[i] = 1'b0; s_wready[i] = 1'b0; s_bvalid[i] = 1'b0;
      end else begin
        s_awready[i] = ($urandom_range(0, 3) != 0);
        s_wready[i]  = ($urandom_range(0, 3) != 0);
        if (s_b_hs[i]) s_bvalid[i] = 1'b0;
        if (b_fire[i]) begin
          s_bvalid[i] = 1'b1;
          s_bresp[2*i +: 2] = (rsp_q.size() > 0) ? rsp_q.pop_front() : 2'b10;
        end
      end
    end
  end

  // Upstream monitor: route isolation, no AW acceptance while a write is open, B scoreboard
  always @(negedge aclk) begin
    if (aresetn) begin
      checks++;
      for (int i = 0; i < NS; i++) begin
        if (i != cur_dest && (s_awvalid[i] || s_wvalid[i] || s_bready[i])) begin
          errors++;
          $display("FAIL route_isolation: slave %0d awvalid=%b wvalid=%b bready=%b, expected 0 (dest=%0d)",
                   i, s_awvalid[i], s_wvalid[i], s_bready[i], cur_dest);
        end
      end
      if (aw_open) begin
        checks++;
        if (m_awready) begin errors++; $display("FAIL awready_open: awready=1, expected 0 while a write is open"); end
      end
      if (m_bvalid && m_bready) begin
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++; $display("FAIL b_resp: got unexpected B bresp=%b, expected none", m_bresp);
        end else begin
          b_exp = exp_b_q.pop_front();
          if (m_bresp != b_exp) begin errors++; $display("FAIL b_resp: got bresp=%b, expected %b", m_bresp, b_exp); end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (m_awready || m_wready || m_bvalid || m_bresp != 2'b00 || s_awaddr != '0 || s_awvalid != '0 ||
        s_wdata != '0 || s_wstrb != '0 || s_wvalid != '0 || s_bready != '0) begin
      errors++;
      $display("FAIL %s: awready=%b wready=%b bvalid=%b bresp=%b s_awvalid=%b s_wvalid=%b s_bready=%b s_awaddr=%h, expected all 0",
               name, m_awready, m_wready, m_bvalid, m_bresp, s_awvalid, s_wvalid, s_bready, s_awaddr);
    end
  endtask

  // w_lead > 0: W raised that many cycles before AW; w_lead < 0: W raised after AW
  task automatic m_req(input int sel, input bit inv, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] strb, input int w_lead, input bit flip, input logic [1:0] br);
    exp_t e;
    int aw_at, w_at, cyc;
    bit aw_ok, w_ok, aw_hs, w_hs;
    if (inv || sel >= NS) begin
      cur_dest = -1;
      exp_b_q.push_back(2'b11);
    end else begin
      cur_dest = sel;
      e.slv = sel; e.addr = addr; e.data = data; e.strb = strb;
      exp_slv_q.push_back(e);
      rsp_q.push_back(br);
      exp_b_q.push_back(br);
    end
    aw_at = (w_lead > 0) ? w_lead : 0;
    w_at  = (w_lead < 0) ? -w_lead : 0;
    aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 200) begin
      if (!aw_ok && cyc == aw_at) begin m_awvalid = 1'b1; m_awaddr = addr; slv_sel = SW'(sel); slv_invalid = inv; end
      if (!w_ok && cyc == w_at) begin m_wvalid = 1'b1; m_wdata = data; m_wstrb = strb; end
      @(negedge aclk);
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      if (cyc == aw_at) begin
        checks++;
        if (m_awready) begin errors++; $display("FAIL aw_latency: awready=1 in first awvalid cycle, expected 0"); end
      end
      if (w_lead > 0 && cyc <= aw_at) begin
        checks++;
        if (m_wready) begin errors++; $display("FAIL w_before_aw: wready=1 at cycle %0d, expected 0", cyc); end
      end
      @(posedge aclk); #1;
      if (aw_hs) begin
        aw_ok = 1'b1; m_awvalid = 1'b0; m_awaddr = $urandom; aw_open = 1'b1;
        slv_sel = flip ? SW'(3) : SW'($urandom_range(0, 7));
        slv_invalid = 1'($urandom_range(0, 1));
      end
      if (w_hs) begin w_ok = 1'b1; m_wvalid = 1'b0; m_wdata = $urandom; end
      cyc++;
    end
    if (!(aw_ok && w_ok)) begin
      checks++; errors++;
      $display("FAIL req_timeout: aw_done=%b w_done=%b, expected both 1", aw_ok, w_ok);
      m_awvalid = 1'b0; m_wvalid = 1'b0;
    end
  endtask

  task automatic m_resp(input int b_stall);
    int cyc, seen;
    bit done, bv_hold;
    done = 1'b0; cyc = 0; seen = 0; bv_hold = 1'b0;
    m_bready = (b_stall == 0);
    while (!done && cyc < 200) begin
      @(negedge aclk);
      if (bv_hold) begin
        checks++;
        if (!m_bvalid) begin errors++; $display("FAIL bvalid_hold: bvalid=0 before handshake, expected 1"); end
      end
      if (m_bvalid && m_bready) done = 1'b1;
      else if (m_bvalid) seen++;
      bv_hold = m_bvalid && !m_bready;
      @(posedge aclk); #1;
      if (done) m_bready = 1'b0;
      else if (seen >= b_stall) m_bready = 1'b1;
      cyc++;
    end
    if (!done) begin checks++; errors++; $display("FAIL resp_timeout: no B handshake, expected one"); end
    m_bready = 1'b0;
    aw_open = 1'b0;
  endtask

  task automatic m_write(input int sel, input bit inv, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DW/8-1:0] strb, input int w_lead, input int b_stall, input bit flip,
                         input logic [1:0] br);
    m_req(sel, inv, addr, data, strb, w_lead, flip, br);
    m_resp(b_stall);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check_zero("reset_outputs");
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_zero("idle_outputs");

    m_write(2, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 2'b00);
    m_write(1, 1'b0, $urandom, $urandom, 4'h3, 3, 1, 1'b0, 2'b10);
    m_write(1, 1'b1, $urandom, $urandom, 4'hF, 0, 5, 1'b0, 2'b00);
    m_write(NS, 1'b0, $urandom, $urandom, 4'h1, -2, 5, 1'b0, 2'b00);
    m_write(1, 1'b0, 32'h0000_1000, 32'h1234_5678, 4'hC, 0, 0, 1'b1, 2'b01);

    // Reset while the selected slave withholds its response
    hold_b = 1'b1;
    m_req(2, 1'b0, $urandom, $urandom, 4'hF, 0, 1'b0, 2'b01);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    check_zero("reset_mid_resp");
    exp_b_q.delete(); rsp_q.delete(); aw_open = 1'b0; hold_b = 1'b0; cur_dest = -1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    m_write(0, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b0, 2'b00);

    for (int k = 0; k < 8; k++) begin
      m_write(k % NS, 1'b0, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
              int'($urandom_range(0, 2)), 1'b0, 2'($urandom));
    end
    for (int k = 0; k < 20; k++) begin
      m_write(int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), 1'b0, 2'($urandom));
    end

    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (exp_slv_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending slave writes=%0d B responses=%0d, expected 0 and 0", exp_slv_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_wr_demux_n.md
# axil_wr_demux_n

Parametrised AXI-Lite write-channel demultiplexer: routes one upstream master's write transactions to one of NUM_SLV downstream slaves. The destination is latched when the transaction opens. Undecodable destinations are terminated locally with DECERR. Sits between the address decoder and the slave ports of the priority interconnect; it replaces the fixed two-way combinational write mux with a tracked, one-outstanding-transaction router.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8
- AXI_ADDR_WIDTH, 32, address width
- NUM_SLV, 4, number of downstream slave ports (>= 2)
- SEL_WIDTH, $clog2(NUM_SLV), width of slv_sel

Ports (clock and reset first):
- aclk  in  1  clock; one clock domain; all I/O synchronous to rising edge
- aresetn  in  1  reset; asynchronous, active-low
- slv_sel  in  SEL_WIDTH  decoded destination index for current m_axil_awaddr
- slv_invalid  in  1  decoder found no slave for m_axil_awaddr
- m_axil_awaddr / awvalid / awready  in/in/out  ADDR/1/1  upstream AW channel
- m_axil_wdata / wstrb / wvalid / wready  in/in/in/out  DATA/DATA/8/1/1  upstream W channel
- m_axil_bresp / bvalid / bready  out/out/in  2/1/1  upstream B channel
- s_axil_awaddr  out  NUM_SLV*ADDR  per-slave AW address, slice i = slave i
- s_axil_awvalid / awready  out/in  NUM_SLV each  per-slave AW handshake
- s_axil_wdata / wstrb  out  NUM_SLV*DATA / NUM_SLV*DATA/8  per-slave W payload
- s_axil_wvalid / wready  out/in  NUM_SLV each
- s_axil_bresp  in  NUM_SLV*2; s_axil_bvalid in / s_axil_bready out  NUM_SLV each

## Operation
- States: IDLE, FWD, RESP, ERR_DATA, ERR_RESP.
- IDLE: all m_axil ready/valid outputs and all s_axil valid/ready outputs are 0. When m_axil_awvalid=1, sample slv_sel and slv_invalid into sel_q:
  - Invalid when slv_invalid=1 or slv_sel >= NUM_SLV; go to ERR_DATA.
  - Otherwise go to FWD.
- FWD:
  - s_axil_awvalid[sel_q] = m_axil_awvalid & ~aw_done; s_axil_wvalid[sel_q] = m_axil_wvalid & ~w_done.
  - m_axil_awready = s_axil_awready[sel_q] & ~aw_done; likewise wready.
  - aw_done/w_done are set on the respective handshake. AW and W complete in either order or the same cycle.
  - Go to RESP in the cycle after both flags are set.
- RESP: upstream B channel follows slave sel_q. On the bvalid & bready handshake, go to IDLE and clear the flags.
- Non-selected slaves always see valid=0 and bready=0. Payloads are broadcast to every slice; only the valid is gated.
- ERR_DATA: m_axil_awready and m_axil_wready each pulse 1 for one handshake, tracked by the same aw_done/w_done flags. No slave is touched. Go to ERR_RESP when both flags are set.
- ERR_RESP: m_axil_bvalid=1, m_axil_bresp=2'b11 (DECERR), held until m_axil_bready; then go to IDLE.
- W arriving before AW in IDLE is held (wready=0) until the route is latched.
- slv_sel/slv_invalid changes after latching are ignored until the next IDLE.

## Timing
- Reset: state=IDLE, flags cleared, sel_q=0. All outputs 0, including m_axil_bresp and every s_axil_* output.
- Reset asserted mid-transaction: abort to IDLE immediately (asynchronous). The in-flight transaction is discarded with no B response.
- Routing latency: AW is accepted at the earliest 1 cycle after awvalid rises (IDLE→FWD costs one cycle).
- In FWD, valid/ready pass-through is combinational and adds zero latency.
- B pass-through is combinational without AXIL_WR_DEMUX_BRESP_REG_EN.
- Minimum transaction with a zero-wait slave: 4 cycles, IDLE→FWD→RESP→IDLE plus the handshake cycle.
- Exactly one outstanding transaction. m_axil_awready=0 in RESP, ERR_RESP and IDLE.
- Once asserted, a valid is held until its handshake, per AXI.

## Configuration
- AXIL_WR_DEMUX_BRESP_REG_EN defined: B path goes through a one-entry register.
  - In RESP, s_axil_bready[sel_q]=1 while the register is empty; bresp is captured on the slave handshake.
  - Next cycle, m_axil_bvalid=1 with the registered bresp, held until m_axil_bready.
  - This adds 1 cycle of B latency and cuts the combinational bready/bvalid path.
- Undefined: B is passed through combinationally as described under FWD/RESP.

## Test plan
- Route to slave 2: slv_sel=2, addr=0x40, data=0xDEADBEEF, strb=0xF. Expect:
  - s_axil_awvalid=4'b0100 and slice 2 carries the payload.
  - Slave returns bresp=2'b00, which appears upstream; all other slices stay valid=0.
- W before AW: wvalid is raised 3 cycles before awvalid. Expect:
  - wready=0 until FWD.
  - Both handshakes complete and exactly one B is returned.
- Decode error: slv_invalid=1, then separately slv_sel=NUM_SLV. Expect:
  - AW and W are accepted locally.
  - bresp=2'b11, bvalid held for 5 cycles of bready=0.
  - No s_axil_*valid asserts.
- Sel change mid-transaction: slv_sel is switched 1→3 while in FWD. Expect the transaction to complete on slave 1 only.
- Reset mid-RESP: aresetn is pulled low while slave bvalid=0. Expect all outputs to be 0 immediately; after release, a new write to slave 0 completes normally.
- Back-to-back: 8 writes round-robin over slaves 0–3 with random ready stalls. Expect:
  - Each B matches its slave's bresp.
  - No overlap, and no awready is accepted while in RESP.
